// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI burst master.
// Each accepted command becomes one INCR burst of byte-wide beats. Bursts that would
// cross the slave window are rejected locally with SLVERR and cause no bus traffic.
module axi_burst_master #(
    parameter logic [2:0]  ID_VAL   = 3'd0,
    parameter logic [31:0] BOUNDARY = 32'h1000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    // command interface
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    // write-data stream
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [7:0]  wd_data,
    // read-data stream
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    // completion
    output logic        done,
    output logic [1:0]  done_resp,
    // write address channel
    output logic [2:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [7:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    // write data channel
    output logic [7:0]  WDATA,
    output logic        WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    // write response channel
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    // read address channel
    output logic [2:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    // read data channel
    input  logic [7:0]  RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // AXI responses are ordered by severity, so the worst is the numerically largest
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t      r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic        r_awvalid;
    logic        r_arvalid;
    logic        r_done;
    logic [1:0]  r_resp;
    logic [1:0]  r_rresp;
    // set for the one cycle after the final read beat; the read channel is closed then
    logic        r_rfin;

    logic [12:0] w_end;
    logic        w_range_err;
    logic        w_cnt_last;
    logic        w_in_w;
    logic        w_in_r;
    logic        w_wfire;
    logic        w_rfire;
    logic        w_rlast_bad;
    logic [1:0]  w_beat_resp;
    logic [1:0]  w_resp_acc;

    // end offset inside the window, kept one bit wider than the offset so it never wraps
    assign w_end       = {1'b0, cmd_addr[11:0]} + {5'd0, cmd_len};
    assign w_range_err = ({19'd0, w_end} >= BOUNDARY);

    assign w_cnt_last  = (r_cnt == r_len);
    assign w_in_w      = (r_state == S_W);
    assign w_in_r      = (r_state == S_R) && !r_rfin;
    assign w_wfire     = w_in_w && wd_valid && WREADY;
    assign w_rfire     = w_in_r && RVALID && rd_ready;

    // a slave whose RLAST disagrees with our own beat count is reported as SLVERR
    assign w_rlast_bad = (RLAST != w_cnt_last);
    assign w_beat_resp = worst_resp(RRESP, w_rlast_bad ? 2'b10 : 2'b00);
    assign w_resp_acc  = worst_resp(r_rresp, w_beat_resp);

    assign cmd_ready = (r_state == S_IDLE) && !ARESET;

    assign AWID    = ID_VAL;
    assign AWADDR  = r_addr;
    assign AWLEN   = r_len;
    assign AWSIZE  = 3'd0;
    assign AWBURST = 2'b01;
    assign AWVALID = r_awvalid;

    assign WDATA    = wd_data;
    assign WSTRB    = 1'b1;
    assign WLAST    = w_in_w && w_cnt_last;
    assign WVALID   = w_in_w && wd_valid;
    assign wd_ready = w_in_w && WREADY;

    assign BREADY = (r_state == S_B);

    assign ARID    = ID_VAL;
    assign ARADDR  = r_addr;
    assign ARLEN   = r_len;
    assign ARSIZE  = 3'd0;
    assign ARBURST = 2'b01;
    assign ARVALID = r_arvalid;

    assign RREADY   = w_in_r && rd_ready;
    assign rd_valid = w_in_r && RVALID;
    assign rd_data  = RDATA;
    assign rd_last  = w_in_r && w_cnt_last;

    assign done      = r_done;
    assign done_resp = r_resp;

    // transaction FSM: command acceptance, address phase, beat counting and completion
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= S_IDLE;
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_cnt     <= 8'd0;
            r_awvalid <= 1'b0;
            r_arvalid <= 1'b0;
            r_done    <= 1'b0;
            r_resp    <= 2'b00;
            r_rresp   <= 2'b00;
            r_rfin    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_len   <= cmd_len;
                        r_cnt   <= 8'd0;
                        r_rresp <= 2'b00;
                        if (w_range_err) begin
                            // done is raised now so it coincides with the ERR cycle
                            r_state <= S_ERR;
                            r_done  <= 1'b1;
                            r_resp  <= 2'b10;
                        end else if (cmd_write) begin
                            r_state   <= S_AW;
                            r_awvalid <= 1'b1;
                        end else begin
                            r_state   <= S_AR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                S_AW: begin
                    if (AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (w_wfire) begin
                        if (w_cnt_last) begin
                            r_cnt   <= 8'd0;
                            r_state <= S_B;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_B: begin
                    if (BVALID) begin
                        r_done  <= 1'b1;
                        r_resp  <= BRESP;
                        r_state <= S_IDLE;
                    end
                end
                S_AR: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (r_rfin) begin
                        r_rfin  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_rfire) begin
                        r_rresp <= w_resp_acc;
                        if (w_cnt_last) begin
                            r_cnt  <= 8'd0;
                            r_rfin <= 1'b1;
                            r_done <= 1'b1;
                            r_resp <= w_resp_acc;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Testbench for axi_burst_master: AXI slave model with byte memory, reference memory,
// and scoreboard queues for write beats, read beats and completion responses.
`timescale 1ns/1ps
module tb_axi_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [7:0]  wd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [7:0]  rd_data;
    logic        done;
    logic [1:0]  done_resp;
    logic [2:0]  AWID, AWSIZE, ARID, ARSIZE;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN, WDATA, RDATA;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WSTRB, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi_burst_master #(.ID_VAL(3'd5), .BOUNDARY(32'h1000)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed { logic [7:0] d; logic last; } beat_t;
    beat_t      exp_wq[$];
    beat_t      exp_rq[$];
    logic [7:0] wdq[$];

    logic [7:0] smem    [4096];
    logic [7:0] ref_mem [4096];

    // slave configuration
    int         aw_dly = 0;
    logic [1:0] bresp_cfg = 2'b00;
    int         bad_beat = -1;
    int         bad_last = -1;
    bit         gaps = 0;
    bit         rtog = 0;

    // slave state
    int          aw_wait, ar_wait, s_wbeat, s_wlen, s_rbeat, s_rlen;
    logic [31:0] s_waddr, s_raddr;
    bit          b_pend, r_act;
    bit          f_aw, f_w, f_b, f_ar, f_r;
    int          aw_seen = 0, ar_seen = 0, w_beats = 0, cyc = 0, r_last_cyc = 0;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;

    task automatic slave_clear();
        wdq.delete();
        AWREADY = 0; ARREADY = 0; WREADY = 0; BVALID = 0; RVALID = 0; RLAST = 0;
        RDATA = 0; RRESP = 0; BRESP = 0; wd_valid = 0; wd_data = 0;
        b_pend = 0; r_act = 0; aw_wait = 0; ar_wait = 0;
        f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
    endtask

    // slave and data-stream driver: drive on the falling edge, decide transfers 1ns later
    initial begin
        rd_ready = 1'b1;
        slave_clear();
        for (int i = 0; i < 4096; i++) begin
            smem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        forever begin
            @(negedge ACLK);
            cyc++;
            if (ARESET) begin
                slave_clear();
                continue;
            end
            if (f_aw) AWREADY = 0;
            if (f_ar) ARREADY = 0;
            if (f_w && wdq.size() > 0) void'(wdq.pop_front());
            if (f_b) BVALID = 0;
            if (f_r) RVALID = 0;
            if (AWVALID) aw_seen++;
            if (ARVALID) ar_seen++;
            if (AWVALID && !AWREADY) begin
                if (aw_wait >= aw_dly) AWREADY = 1; else aw_wait++;
            end
            if (ARVALID && !ARREADY) begin
                if (ar_wait >= aw_dly) ARREADY = 1; else ar_wait++;
            end
            wd_valid = (wdq.size() > 0);
            wd_data  = wd_valid ? wdq[0] : 8'h00;
            WREADY   = 1;
            BVALID   = b_pend;
            BRESP    = bresp_cfg;
            if (r_act && !RVALID) begin
                if (!gaps || ($urandom_range(0, 1) == 1)) begin
                    RVALID = 1;
                    RDATA  = smem[(s_raddr + s_rbeat) & 32'hFFF];
                    RRESP  = (s_rbeat == bad_beat) ? 2'b10 : 2'b00;
                    RLAST  = (s_rbeat == s_rlen) ^ (s_rbeat == bad_last);
                end
            end
            rd_ready = rtog ? ~rd_ready : 1'b1;
            #1;
            f_aw = AWVALID && AWREADY;
            f_ar = ARVALID && ARREADY;
            f_w  = WVALID && WREADY;
            f_b  = BVALID && BREADY;
            f_r  = RVALID && RREADY;
            if (f_aw) begin
                chk("awaddr", AWADDR, exp_addr);
                chk("awlen", {24'd0, AWLEN}, {24'd0, exp_len});
                chk("awid", {29'd0, AWID}, 32'd5);
                s_waddr = AWADDR; s_wlen = AWLEN; s_wbeat = 0; aw_wait = 0;
            end
            if (f_ar) begin
                chk("araddr", ARADDR, exp_addr);
                chk("arlen", {24'd0, ARLEN}, {24'd0, exp_len});
                s_raddr = ARADDR; s_rlen = ARLEN; s_rbeat = 0; ar_wait = 0; r_act = 1;
            end
            if (f_w) begin
                w_beats++;
                if (exp_wq.size() == 0) begin
                    chk("w_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = exp_wq.pop_front();
                    chk("wdata", {24'd0, WDATA}, {24'd0, e.d});
                    chk("wlast", {31'd0, WLAST}, {31'd0, e.last});
                end
                smem[(s_waddr + s_wbeat) & 32'hFFF] = WDATA;
                if (s_wbeat == s_wlen) b_pend = 1;
                s_wbeat++;
            end
            if (f_b) b_pend = 0;
            if (f_r) begin
                if (exp_rq.size() == 0) begin
                    chk("r_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = exp_rq.pop_front();
                    chk("rd_data", {24'd0, rd_data}, {24'd0, e.d});
                    chk("rd_last", {31'd0, rd_last}, {31'd0, e.last});
                end
                s_rbeat++;
                if (s_rbeat > s_rlen) begin
                    r_act = 0;
                    r_last_cyc = cyc;
                end
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] a, input logic [7:0] l, output bit ok);
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        exp_addr = a; exp_len = l;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (cmd_ready) begin
                ok = 1;
                @(negedge ACLK);
                break;
            end
            @(negedge ACLK);
        end
        cmd_valid = 0;
        if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input logic [1:0] eresp, input bit is_err, input bit is_rd);
        bit seen = 0;
        int lat = 0;
        for (int i = 0; i < 300; i++) begin
            #2;
            if (done) begin
                seen = 1;
                lat = i;
                break;
            end
            @(negedge ACLK);
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_resp", {30'd0, done_resp}, {30'd0, eresp});
            if (is_err) begin
                chk("err_done_latency", lat, 0);
                chk("err_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            end else if (is_rd) begin
                chk("rd_done_cycle", cyc, r_last_cyc + 1);
                chk("rd_done_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            end
            @(negedge ACLK);
            #2;
            chk("done_pulse_width", {31'd0, done}, 32'd0);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  seed;
        int          dly;
        logic [1:0]  bresp;
        int          bbeat;
        int          blast;
        bit          gp;
        bit          tg;
        bit          err;
        logic [1:0]  eresp;
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit ok;
        int aws, ars;
        aw_dly = v.dly; bresp_cfg = v.bresp; bad_beat = v.bbeat; bad_last = v.blast;
        gaps = v.gp; rtog = v.tg;
        if (!v.err) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                beat_t e;
                if (v.wr) begin
                    e.d = v.seed + 8'(i);
                    wdq.push_back(e.d);
                    ref_mem[(v.addr + i) & 32'hFFF] = e.d;
                end else begin
                    e.d = ref_mem[(v.addr + i) & 32'hFFF];
                end
                e.last = (i == int'(v.len));
                if (v.wr) exp_wq.push_back(e); else exp_rq.push_back(e);
            end
        end
        aws = aw_seen; ars = ar_seen;
        issue(v.wr, v.addr, v.len, ok);
        if (ok) wait_done(v.eresp, v.err, !v.wr && !v.err);
        if (v.err) begin
            chk("err_no_aw", aw_seen, aws);
            chk("err_no_ar", ar_seen, ars);
        end
        chk("wq_drained", exp_wq.size(), 0);
        chk("rq_drained", exp_rq.size(), 0);
        exp_wq.delete(); exp_rq.delete(); wdq.delete();
    endtask

    vec_t vecs[13];

    initial begin
        bit ok;
        int base;
        vecs[0]  = '{1'b1, 32'h010, 8'd3, 8'hA1, 2, 2'b00, -1, -1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 32'h010, 8'd3, 8'h00, 0, 2'b00, -1, -1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[2]  = '{1'b1, 32'hFFE, 8'd3, 8'h00, 0, 2'b00, -1, -1, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[3]  = '{1'b1, 32'hFFC, 8'd3, 8'h50, 1, 2'b00, -1, -1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{1'b0, 32'hFFC, 8'd3, 8'h00, 1, 2'b00, -1, -1, 1'b1, 1'b1, 1'b0, 2'b00};
        vecs[5]  = '{1'b1, 32'h200, 8'd7, 8'h30, 0, 2'b01, -1, -1, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[6]  = '{1'b0, 32'h200, 8'd7, 8'h00, 0, 2'b00,  2, -1, 1'b1, 1'b1, 1'b0, 2'b10};
        vecs[7]  = '{1'b1, 32'h300, 8'd0, 8'h77, 3, 2'b00, -1, -1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[8]  = '{1'b0, 32'h300, 8'd0, 8'h00, 0, 2'b00, -1, -1, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[9]  = '{1'b0, 32'hFFF, 8'd1, 8'h00, 0, 2'b00, -1, -1, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[10] = '{1'b0, 32'hFFE, 8'd1, 8'h00, 0, 2'b00, -1, -1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[11] = '{1'b0, 32'h010, 8'd3, 8'h00, 0, 2'b00, -1,  1, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[12] = '{1'b0, 32'hFFC, 8'd3, 8'h00, 0, 2'b00, -1,  3, 1'b1, 1'b0, 1'b0, 2'b10};

        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        repeat (3) @(negedge ACLK);
        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_awvalid", {31'd0, AWVALID}, 32'd0);
        chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_done_resp", {30'd0, done_resp}, 32'd0);
        chk("rst_awaddr", AWADDR, 32'd0);
        @(negedge ACLK);
        ARESET = 0;
        #2;
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int k = 0; k < 13; k++) run_vec(vecs[k]);

        // reset in the middle of a write burst, after its second beat
        aw_dly = 0; bresp_cfg = 2'b00; gaps = 0; rtog = 0; bad_beat = -1; bad_last = -1;
        for (int i = 0; i < 4; i++) begin
            beat_t e;
            e.d = 8'h90 + 8'(i);
            e.last = (i == 3);
            wdq.push_back(e.d);
            exp_wq.push_back(e);
        end
        base = w_beats;
        issue(1'b1, 32'h400, 8'd3, ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            #2;
            if (w_beats >= base + 2) begin
                ok = 1;
                break;
            end
            @(negedge ACLK);
        end
        if (!ok) chk("midburst_beat_timeout", 32'd0, 32'd1);
        @(posedge ACLK);
        #3;
        ARESET = 1;
        #1;
        chk("mid_rst_awvalid", {31'd0, AWVALID}, 32'd0);
        chk("mid_rst_wvalid", {31'd0, WVALID}, 32'd0);
        chk("mid_rst_wd_ready", {31'd0, wd_ready}, 32'd0);
        chk("mid_rst_wlast", {31'd0, WLAST}, 32'd0);
        chk("mid_rst_bready", {31'd0, BREADY}, 32'd0);
        chk("mid_rst_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("mid_rst_rready", {31'd0, RREADY}, 32'd0);
        chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_rst_rd_last", {31'd0, rd_last}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_done_resp", {30'd0, done_resp}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("mid_rst_awaddr", AWADDR, 32'd0);
        chk("mid_rst_awlen", {24'd0, AWLEN}, 32'd0);
        exp_wq.delete(); wdq.delete();
        repeat (2) @(negedge ACLK);
        ARESET = 0;
        #2;
        chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        run_vec('{1'b1, 32'h500, 8'd0, 8'h5A, 0, 2'b00, -1, -1, 1'b0, 1'b0, 1'b0, 2'b00});
        run_vec('{1'b0, 32'h500, 8'd0, 8'h00, 0, 2'b00, -1, -1, 1'b0, 1'b0, 1'b0, 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // absolute time bound for the whole run
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
